// File: rtl/param_seq_detector.sv
// Serial bit-pattern detector with a runtime-loadable pattern, length and overlap
// mode, a registered match pulse and a saturating match counter.
module param_seq_detector #(
  parameter int               PAT_W   = 8,
  parameter int               LEN_W   = 4,
  parameter int               CNT_W   = 8,
  parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'(8'b0000_1010),
  parameter int               DEF_LEN = 4,
  parameter bit               DEF_OVL = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  input  logic             din_valid,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pat,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_ovl,
  input  logic             cnt_clr,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic             cfg_err
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(PAT_W);
  localparam logic [LEN_W-1:0] MIN_LEN = LEN_W'(2);
  localparam logic [LEN_W-1:0] RST_LEN = LEN_W'(DEF_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [PAT_W-1:0] pat;
  logic [PAT_W-1:0] hist;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] fill;
  logic             ovl;

  logic [PAT_W-1:0] len_mask;
  logic [PAT_W-1:0] window;
  logic [LEN_W:0]   fill_inc;
  logic             shift_en;
  logic             cfg_ok;
  logic             hit;

  // NOTE: every signal written here gets a value before any branch, so no latch is inferred.
  always_comb begin
    len_mask = '0;
    for (int i = 0; i < PAT_W; i++) begin
      len_mask[i] = (i < int'(len));
    end
    window   = {hist[PAT_W-2:0], din};
    fill_inc = {1'b0, fill} + (LEN_W+1)'(1);
    // A load in the same cycle always swallows the data bit, accepted or not.
    shift_en = din_valid && !cfg_load;
    cfg_ok   = (cfg_len >= MIN_LEN) && (cfg_len <= MAX_LEN);
    hit      = shift_en && (fill_inc >= {1'b0, len}) &&
               ((window & len_mask) == (pat & len_mask));
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pat  <= DEF_PAT;
      len  <= RST_LEN;
      ovl  <= DEF_OVL;
      hist <= '0;
      fill <= '0;
    end else if (cfg_load) begin
      if (cfg_ok) begin
        pat  <= cfg_pat;
        len  <= cfg_len;
        ovl  <= cfg_ovl;
        hist <= '0;
        fill <= '0;
      end
    end else if (din_valid) begin
      hist <= window;
      if (hit) begin
        // Overlap keeps fill saturated so trailing bits can seed the next match.
        fill <= ovl ? len : '0;
      end else if (fill < len) begin
        fill <= fill_inc[LEN_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      match       <= 1'b0;
      cfg_err     <= 1'b0;
      match_count <= '0;
    end else begin
      match   <= hit;
      cfg_err <= cfg_load && !cfg_ok;
      if (cnt_clr) begin
        match_count <= '0;
      end else if (match && (match_count != CNT_MAX)) begin
        match_count <= match_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_param_seq_detector.sv
// Directed bench for param_seq_detector: per-cycle expected match/cfg_err are queued
// as each step is driven and popped for comparison once the clock edge has passed.
module tb_param_seq_detector;

  logic       clk = 1'b0;
  logic       reset;
  logic       din;
  logic       din_valid;
  logic       cfg_load;
  logic [7:0] cfg_pat;
  logic [3:0] cfg_len;
  logic       cfg_ovl;
  logic       cnt_clr;
  logic       match;
  logic [1:0] match_count;
  logic       cfg_err;

  typedef struct packed {
    logic m;
    logic e;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  param_seq_detector #(
    .PAT_W(8), .LEN_W(4), .CNT_W(2),
    .DEF_PAT(8'b0000_1010), .DEF_LEN(4), .DEF_OVL(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .cfg_load(cfg_load), .cfg_pat(cfg_pat), .cfg_len(cfg_len), .cfg_ovl(cfg_ovl),
    .cnt_clr(cnt_clr), .match(match), .match_count(match_count), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock step: drive inputs, queue the expected outputs, compare after the edge.
  task automatic cyc(input logic v, input logic d, input logic ld, input logic clr,
                     input logic [7:0] p, input logic [3:0] l, input logic o,
                     input logic em, input logic ee);
    exp_t got;
    din_valid = v;
    din       = d;
    cfg_load  = ld;
    cnt_clr   = clr;
    cfg_pat   = p;
    cfg_len   = l;
    cfg_ovl   = o;
    sb.push_back('{m: em, e: ee});
    @(posedge clk);
    #1;
    got = sb.pop_front();
    check("match", {7'b0, match}, {7'b0, got.m});
    check("cfg_err", {7'b0, cfg_err}, {7'b0, got.e});
    din_valid = 1'b0;
    cfg_load  = 1'b0;
    cnt_clr   = 1'b0;
  endtask

  task automatic shift(input logic v, input logic d, input logic em);
    cyc(v, d, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, em, 1'b0);
  endtask

  task automatic load(input logic [7:0] p, input logic [3:0] l, input logic o,
                      input logic clr, input logic v, input logic d, input logic ee);
    cyc(v, d, 1'b1, clr, p, l, o, 1'b0, ee);
  endtask

  // Checks outputs while reset is held, before any clock edge, to exercise the async path.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("rst_match", {7'b0, match}, 8'h00);
    check("rst_cfg_err", {7'b0, cfg_err}, 8'h00);
    check("rst_count", {6'b0, match_count}, 8'h00);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    din = 1'b0; din_valid = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0;
    cfg_pat = '0; cfg_len = '0; cfg_ovl = 1'b0;
    reset = 1'b0;
    #2;
    do_reset();

    // Default pattern 1010, overlapping: hits on bits 4 and 6.
    shift(1, 1, 0); shift(1, 0, 0); shift(1, 1, 0); shift(1, 0, 1);
    shift(1, 1, 0); shift(1, 0, 1);
    shift(0, 0, 0);
    check("count_ovl", {6'b0, match_count}, 8'd2);

    // Rejected loads keep the default config; a rejected load still eats its data bit.
    do_reset();
    load(8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    shift(1, 1, 0); shift(1, 0, 0); shift(1, 1, 0);
    load(8'h00, 4'd9, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    shift(1, 0, 1);

    // Non-overlapping 1010 with junk above the length; clear coincides with a match pulse.
    load(8'b1111_1010, 4'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("count_clr_win", {6'b0, match_count}, 8'd0);
    shift(1, 1, 0); shift(1, 0, 0); shift(1, 1, 0); shift(1, 0, 1);
    shift(1, 1, 0); shift(1, 0, 0);
    shift(0, 0, 0);
    check("count_novl", {6'b0, match_count}, 8'd1);

    // Pattern 111 across a five-cycle gap of invalid zeros.
    load(8'b1010_0111, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    shift(1, 1, 0); shift(1, 1, 0);
    for (int i = 0; i < 5; i++) shift(0, 0, 0);
    shift(1, 1, 1);
    shift(0, 0, 0);

    // Two-bit counter saturates on a run of eight 1s with pattern 11.
    load(8'b0000_0011, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    shift(1, 1, 0);
    for (int i = 0; i < 7; i++) shift(1, 1, 1);
    check("count_sat", {6'b0, match_count}, 8'd3);
    cyc(1, 1, 0, 1, 8'h00, 4'd0, 1'b0, 1, 0);
    check("count_clr_match", {6'b0, match_count}, 8'd0);
    shift(0, 0, 0);
    check("count_after_clr", {6'b0, match_count}, 8'd1);

    // Reset mid-sequence discards 101 and restores the default 1010 config.
    do_reset();
    shift(1, 1, 0); shift(1, 0, 0); shift(1, 1, 0);
    do_reset();
    shift(1, 0, 0); shift(1, 1, 0); shift(1, 0, 0);
    shift(1, 1, 0); shift(1, 0, 1); shift(1, 1, 0); shift(1, 0, 1);
    shift(0, 0, 0);
    check("count_post_rst", {6'b0, match_count}, 8'd2);

    check("sb_drained", 8'(sb.size()), 8'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
